conv_pool_write_controller: RTL
===============================

Name: conv_pool_write_controller

Overview:
Write-side counterpart of the CONV2/CONV3 read address generator. It consumes the conv result stream, which arrives in groups of 4 covering one 2x2 pooling window, in the same order the reader issues kernels. It max-pools each group, optionally applies ReLU, and writes one pooled word per group into the feature-map buffer. It generates a raster write address, a write strobe, and a done flag that the layer FSM uses to advance.

Parameters:
DW, 16, signed data width of conv results and pooled output
AW, 9, write address width
OUT_W, 6, pooled output columns per row
OUT_H, 8, pooled output rows
BANK_OFS, 252, address offset added when iSTATE == 3'b011 (second buffer bank)
RELU, 1, 1 = clamp negative pooled values to 0 before write; 0 = pass through

Ports:
iCLK  in  1  clock
iRSTn  in  1  reset; synchronous, active-low
iSTATE  in  3  layer FSM state; 3'b011 selects bank offset
iCLR  in  1  synchronous restart: clears counters and done, keeps parameters
iVALID  in  1  iDATA valid this cycle
iDATA  in  DW  signed conv result
oWr_EN  out  1  write strobe, one cycle per pooled word
oWr_ADDR  out  AW  write address
oWr_DATA  out  DW  pooled (and ReLU'd) value
oWr_DONE  out  1  all OUT_W*OUT_H words written; sticky

Behaviour:
- All state is updated on the iCLK rising edge. iRSTn=0 takes priority over every other input. iCLR=1 is next in priority.
- Reset or iCLR clears the following: pool counter p=0, column c=0, row r=0, max register=0, oWr_EN=0, oWr_ADDR=0, oWr_DATA=0, oWr_DONE=0. The FSM returns to ACCUM.
- FSM has two states.
  - ACCUM: accepts iVALID.
  - DONE: ignores iVALID, holds oWr_DONE=1 and oWr_EN=0, and leaves only via iCLR or reset.
- Pool counter p runs 0..3 and advances on each accepted iVALID.
  - p=0: max register is loaded with iDATA.
  - p=1..3: max register is updated with the signed maximum of itself and iDATA.
- When iVALID arrives with p=3, the write is issued on the next cycle (latency 1):
  - oWr_EN=1 for exactly one cycle.
  - oWr_DATA = signed max of the 4 samples, including the current one. If RELU=1 and the max is negative, it is 0.
  - oWr_ADDR = c + r*OUT_W, plus BANK_OFS if iSTATE==3'b011. iSTATE is sampled in the same cycle as the p=3 sample. The sum is truncated to AW bits.
- After each write, c increments. When c wraps from OUT_W-1 to 0, r increments.
- The write for c=OUT_W-1, r=OUT_H-1 is the final word:
  - oWr_DONE goes to 1 in the same cycle that word's oWr_EN is high.
  - The FSM enters DONE.
- oWr_ADDR and oWr_DATA hold their last values when oWr_EN=0.
- Equal values: ties in the max comparison keep the stored value. Only signed comparison is used; 16'h8000 is the minimum value.
- Gaps: iVALID may deassert for any number of cycles within a group. p, c and r hold during gaps.
- iCLR and iVALID in the same cycle: iCLR wins and the sample is dropped.
- Reset mid-group discards the partial window. No write is issued.
- iVALID in the same cycle oWr_EN is high is accepted normally and starts the next group. The block therefore sustains one sample per cycle with no stall.

Test Plan:
1. Reset, then 4 valids of 5, -3, 9, 2 with iSTATE=0 → one cycle later oWr_EN=1, oWr_ADDR=0, oWr_DATA=9. On the following cycle oWr_EN=0.
2. Group of -7, -2, -9, -4 with RELU=1 → oWr_DATA=0. Same group with RELU=0 → oWr_DATA=-2 (16'hFFFE).
3. Stream 48 groups back-to-back (192 contiguous valids) with iSTATE=0 →
   - 48 strobes at addresses 0..47 in order;
   - oWr_DONE=1 coincident with the addr-47 strobe;
   - 8 extra valids afterwards produce no strobe.
4. Repeat scenario 3 with iSTATE=3'b011 → addresses 252..299, first write of row 1 at 258.
5. Feed 2 samples, pull iRSTn low for 1 cycle, then feed 4 samples of 1, 1, 1, 1 → single write of value 1 at address 0. The partial group is discarded.
6. In the DONE state:
   - assert iCLR together with iVALID=1 → the sample is dropped and oWr_DONE returns to 0;
   - a subsequent 4-sample group then writes at address 0.

Source files
------------

// File: rtl/conv_pool_write_controller_if.sv
// rtl/conv_pool_write_controller_if.sv - conv result stream in, pooled feature-map write port out
interface conv_pool_write_controller_if #(
  parameter int DW = 16,
  parameter int AW = 9
);
  logic [2:0]           iSTATE;
  logic                 iCLR;
  logic                 iVALID;
  logic signed [DW-1:0] iDATA;
  logic                 oWr_EN;
  logic [AW-1:0]        oWr_ADDR;
  logic signed [DW-1:0] oWr_DATA;
  logic                 oWr_DONE;

  modport master (
    output iSTATE, iCLR, iVALID, iDATA,
    input  oWr_EN, oWr_ADDR, oWr_DATA, oWr_DONE
  );

  modport slave (
    input  iSTATE, iCLR, iVALID, iDATA,
    output oWr_EN, oWr_ADDR, oWr_DATA, oWr_DONE
  );
endinterface

// File: rtl/conv_pool_write_controller.sv
// rtl/conv_pool_write_controller.sv - 2x2 max-pool + optional ReLU, raster write into feature-map buffer
module conv_pool_write_controller #(
  parameter int DW       = 16,
  parameter int AW       = 9,
  parameter int OUT_W    = 6,
  parameter int OUT_H    = 8,
  parameter int BANK_OFS = 252,
  parameter int RELU     = 1
) (
  input logic iCLK,
  input logic iRSTn,
  conv_pool_write_controller_if.slave bus
);
  localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int RW = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  localparam logic [0:0] S_ACCUM = 1'b0;
  localparam logic [0:0] S_DONE  = 1'b1;

  logic [0:0]           state;
  logic [1:0]           p;
  logic [CW-1:0]        c;
  logic [RW-1:0]        r;
  logic signed [DW-1:0] max_q;
  logic signed [DW-1:0] cur_max;
  logic signed [DW-1:0] pooled;
  logic [AW-1:0]        addr_next;
  logic                 last_word;

  // Strict greater-than so ties keep the stored value.
  always_comb begin
    cur_max = max_q;
    if (p == 2'd0 || bus.iDATA > max_q) cur_max = bus.iDATA;
    pooled = cur_max;
    if (RELU != 0 && cur_max < 0) pooled = '0;
  end

  always_comb begin
    addr_next = AW'(c) + AW'(r) * AW'(OUT_W);
    if (bus.iSTATE == 3'b011) addr_next = addr_next + AW'(BANK_OFS);
  end

  assign last_word = (c == CW'(OUT_W - 1)) && (r == RW'(OUT_H - 1));

  always_ff @(posedge iCLK) begin
    if (!iRSTn || bus.iCLR) begin
      state        <= S_ACCUM;
      p            <= '0;
      c            <= '0;
      r            <= '0;
      max_q        <= '0;
      bus.oWr_EN   <= 1'b0;
      bus.oWr_ADDR <= '0;
      bus.oWr_DATA <= '0;
      bus.oWr_DONE <= 1'b0;
    end else begin
      bus.oWr_EN <= 1'b0;
      if (state == S_ACCUM && bus.iVALID) begin
        max_q <= cur_max;
        p     <= p + 2'd1;
        if (p == 2'd3) begin
          bus.oWr_EN   <= 1'b1;
          bus.oWr_ADDR <= addr_next;
          bus.oWr_DATA <= pooled;
          if (last_word) begin
            bus.oWr_DONE <= 1'b1;
            state        <= S_DONE;
          end
          if (c == CW'(OUT_W - 1)) begin
            c <= '0;
            r <= r + RW'(1);
          end else begin
            c <= c + CW'(1);
          end
        end
      end
    end
  end
endmodule
